// File: rtl/sda_tx_ctrl_pkg.sv
// Shared types and constants for the I2C slave SDA transmit controller.
package i2c_pkg;

    typedef enum logic [1:0] {IDLE, TX, MACK, ACK} sda_tx_state_t;

    localparam int   HOLD_W      = 4;
    localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/sda_tx_ctrl_if.sv
// Request/status bundle between the slave control FSM and the SDA transmit controller.
interface sda_tx_ctrl_if #(parameter int DATA_W = 8);

    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;
    logic              sda_in;
    logic              tx_load;
    logic [DATA_W-1:0] tx_data;
    logic              ack_req;
    logic              nack_req;
    logic              sda_out;
    logic              tx_busy;
    logic              byte_done;
    logic              mack_valid;
    logic              master_ack;
    logic              tx_abort;

    modport master (
        output scl_rise, scl_fall, start_det, stop_det, sda_in,
               tx_load, tx_data, ack_req, nack_req,
        input  sda_out, tx_busy, byte_done, mack_valid, master_ack, tx_abort
    );

    modport slave (
        input  scl_rise, scl_fall, start_det, stop_det, sda_in,
               tx_load, tx_data, ack_req, nack_req,
        output sda_out, tx_busy, byte_done, mack_valid, master_ack, tx_abort
    );

endinterface

// File: rtl/sda_tx_ctrl_hold_timer.sv
// Delays each scheduled SDA value by HOLD_CYCLES clocks; a newer schedule replaces the pending one.
module sda_hold_timer
    import i2c_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic sched,
    input  logic sched_val,
    input  logic cancel,
    output logic apply_o,
    output logic val_o
);

    // The load edge itself counts as the first hold cycle.
    localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_CYCLES == 0 ? 0 : HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              val_q, val_d;

    always_comb begin
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        val_d   = val_q;
        apply_o = 1'b0;
        val_o   = val_q;
        if (cancel) begin
            pend_d = 1'b0;
        end else begin
            if (pend_q) begin
                if (cnt_q == '0) begin
                    apply_o = 1'b1;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            if (sched) begin
                if (HOLD_CYCLES == 0) begin
                    apply_o = 1'b1;
                    val_o   = sched_val;
                    pend_d  = 1'b0;
                end else begin
                    pend_d = 1'b1;
                    cnt_d  = RELOAD;
                    val_d  = sched_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            val_q  <= SDA_RELEASE;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            val_q  <= val_d;
        end
    end

endmodule

// File: rtl/sda_tx_ctrl.sv
// I2C slave SDA transmit controller: byte serialiser, slave ACK/NACK driver and master-ACK sampler.
module sda_tx_ctrl
    import i2c_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    sda_tx_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W);

    sda_tx_state_t     state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mack_seen_q, mack_seen_d;
    logic              sda_out_q, sda_out_d;
    logic              byte_done_q, byte_done_d;
    logic              mack_valid_q, mack_valid_d;
    logic              master_ack_q, master_ack_d;
    logic              tx_abort_q, tx_abort_d;

    logic sched, sched_val, cancel;
    logic hold_apply, hold_val;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        mack_seen_d  = mack_seen_q;
        byte_done_d  = 1'b0;
        mack_valid_d = 1'b0;
        master_ack_d = master_ack_q;
        tx_abort_d   = 1'b0;
        sched        = 1'b0;
        sched_val    = SDA_RELEASE;
        cancel       = 1'b0;

        // Bus conditions override any transfer and flush the pending SDA change.
        if (bus.start_det || bus.stop_det) begin
            cancel     = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
            tx_abort_d = (state_q != IDLE);
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ack_req) begin
                        state_d   = ACK;
                        sched     = 1'b1;
                        sched_val = 1'b0;
                    end else if (bus.nack_req) begin
                        state_d   = ACK;
                        sched     = 1'b1;
                        sched_val = SDA_RELEASE;
                    end else if (bus.tx_load) begin
                        state_d   = TX;
                        shreg_d   = bus.tx_data;
                        cnt_d     = CNT_W'(DATA_W - 1);
                        sched     = 1'b1;
                        sched_val = bus.tx_data[DATA_W-1];
                    end
                end
                TX: begin
                    if (bus.scl_fall) begin
                        sched = 1'b1;
                        if (cnt_q == '0) begin
                            state_d     = MACK;
                            mack_seen_d = 1'b0;
                        end else begin
                            cnt_d     = cnt_q - 1'b1;
                            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                            sched_val = shreg_q[DATA_W-2];
                        end
                    end
                end
                MACK: begin
                    if (bus.scl_rise && !mack_seen_q) begin
                        mack_seen_d  = 1'b1;
                        mack_valid_d = 1'b1;
                        master_ack_d = ~bus.sda_in;
                    end else if (bus.scl_fall && mack_seen_q) begin
                        byte_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                ACK: begin
                    if (bus.scl_fall) begin
                        sched   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sda_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk       (clk),
        .n_rst     (n_rst),
        .sched     (sched),
        .sched_val (sched_val),
        .cancel    (cancel),
        .apply_o   (hold_apply),
        .val_o     (hold_val)
    );

    always_comb begin
        sda_out_d = sda_out_q;
        if (cancel)          sda_out_d = SDA_RELEASE;
        else if (hold_apply) sda_out_d = hold_val;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            mack_seen_q  <= 1'b0;
            sda_out_q    <= SDA_RELEASE;
            byte_done_q  <= 1'b0;
            mack_valid_q <= 1'b0;
            master_ack_q <= 1'b0;
            tx_abort_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            mack_seen_q  <= mack_seen_d;
            sda_out_q    <= sda_out_d;
            byte_done_q  <= byte_done_d;
            mack_valid_q <= mack_valid_d;
            master_ack_q <= master_ack_d;
            tx_abort_q   <= tx_abort_d;
        end
    end

    assign bus.sda_out    = sda_out_q;
    assign bus.tx_busy    = (state_q != IDLE);
    assign bus.byte_done  = byte_done_q;
    assign bus.mack_valid = mack_valid_q;
    assign bus.master_ack = master_ack_q;
    assign bus.tx_abort   = tx_abort_q;

endmodule

// File: tb/tb_sda_tx_ctrl.sv
// Directed bench for sda_tx_ctrl: per-cycle scoreboard of sda_out and the event pulses.
module tb_sda_tx_ctrl;
    import i2c_pkg::*;

    localparam int DATA_W = 8;
    localparam int HOLD   = 2;
    localparam int LOW    = 4;
    localparam int HIGH   = 3;
    localparam int K_SDA = 0, K_DONE = 1, K_MVAL = 2, K_ABORT = 3;

    typedef struct {
        int   cyc;
        logic val;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    sda_tx_ctrl_if #(.DATA_W(DATA_W)) bus ();

    sda_tx_ctrl #(.DATA_W(DATA_W), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    exp_t sda_q[$], done_q[$], mval_q[$], abort_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;
    logic prev_sda = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expectation lands dly edges after the edge that samples the current drive.
    task automatic push(input int kind, input int dly, input logic v);
        exp_t x;
        x.cyc = cyc + dly;
        x.val = v;
        case (kind)
            K_SDA:   sda_q.push_back(x);
            K_DONE:  done_q.push_back(x);
            K_MVAL:  mval_q.push_back(x);
            default: abort_q.push_back(x);
        endcase
    endtask

    // sda_out must only move where an expectation says so; pulses only where pushed.
    always @(negedge clk) begin : monitor
        logic e;
        if (chk_en) begin
            e = prev_sda;
            if (sda_q.size() > 0 && sda_q[0].cyc == cyc) begin
                e = sda_q[0].val;
                void'(sda_q.pop_front());
            end
            check("sda_out", bus.sda_out, e);
            prev_sda = e;

            e = 1'b0;
            if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
                e = 1'b1;
                void'(done_q.pop_front());
            end
            check("byte_done", bus.byte_done, e);

            e = 1'b0;
            if (abort_q.size() > 0 && abort_q[0].cyc == cyc) begin
                e = 1'b1;
                void'(abort_q.pop_front());
            end
            check("tx_abort", bus.tx_abort, e);

            e = 1'b0;
            if (mval_q.size() > 0 && mval_q[0].cyc == cyc) begin
                e = 1'b1;
                check("master_ack", bus.master_ack, mval_q[0].val);
                void'(mval_q.pop_front());
            end
            check("mack_valid", bus.mack_valid, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.scl_rise  = 1'b0;
        bus.scl_fall  = 1'b0;
        bus.start_det = 1'b0;
        bus.stop_det  = 1'b0;
        bus.tx_load   = 1'b0;
        bus.ack_req   = 1'b0;
        bus.nack_req  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic scl_high(input logic sda);
        bus.sda_in   = sda;
        bus.scl_rise = 1'b1;
        tick();
        idle(HIGH);
    endtask

    task automatic scl_low(input logic nxt);
        push(K_SDA, 1 + HOLD, nxt);
        bus.scl_fall = 1'b1;
        tick();
        idle(LOW);
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] data, input logic mbit);
        bus.tx_data = data;
        bus.tx_load = 1'b1;
        push(K_SDA, 1 + HOLD, data[DATA_W-1]);
        tick();
        check("busy_on_load", bus.tx_busy, 1'b1);
        idle(LOW);
        for (int b = DATA_W - 1; b >= 0; b--) begin
            scl_high(data[b]);
            scl_low(b > 0 ? data[b-1] : 1'b1);
        end
        push(K_MVAL, 1, ~mbit);
        scl_high(mbit);
        push(K_DONE, 1, 1'b1);
        bus.scl_fall = 1'b1;
        tick();
        check("busy_after_byte", bus.tx_busy, 1'b0);
        idle(LOW);
        bus.sda_in = 1'b1;
    endtask

    task automatic slave_ack_clock(input logic drive_nack);
        scl_high(drive_nack);
        push(K_SDA, 1 + HOLD, 1'b1);
        bus.scl_fall = 1'b1;
        tick();
        check("busy_after_ack", bus.tx_busy, 1'b0);
        idle(LOW);
    endtask

    initial begin
        n_rst         = 1'b0;
        bus.scl_rise  = 1'b0;
        bus.scl_fall  = 1'b0;
        bus.start_det = 1'b0;
        bus.stop_det  = 1'b0;
        bus.sda_in    = 1'b1;
        bus.tx_load   = 1'b0;
        bus.tx_data   = '0;
        bus.ack_req   = 1'b0;
        bus.nack_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sda_out", bus.sda_out, 1'b1);
        check("rst_tx_busy", bus.tx_busy, 1'b0);
        check("rst_byte_done", bus.byte_done, 1'b0);
        check("rst_mack_valid", bus.mack_valid, 1'b0);
        check("rst_master_ack", bus.master_ack, 1'b0);
        check("rst_tx_abort", bus.tx_abort, 1'b0);
        n_rst  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        send_byte(8'hA5, 1'b0);
        check("ack_held_a5", bus.master_ack, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("nack_held_ff", bus.master_ack, 1'b0);

        // Slave ACK then slave NACK
        bus.ack_req = 1'b1;
        push(K_SDA, 1 + HOLD, 1'b0);
        tick();
        check("busy_in_ack", bus.tx_busy, 1'b1);
        idle(LOW);
        slave_ack_clock(1'b0);
        bus.nack_req = 1'b1;
        push(K_SDA, 1 + HOLD, 1'b1);
        tick();
        check("busy_in_nack", bus.tx_busy, 1'b1);
        idle(LOW);
        slave_ack_clock(1'b1);

        // STOP one cycle after the third bit's fall: the pending bit must be cancelled
        bus.tx_data = 8'h00;
        bus.tx_load = 1'b1;
        push(K_SDA, 1 + HOLD, 1'b0);
        tick();
        idle(LOW);
        scl_high(1'b0);
        scl_low(1'b0);
        scl_high(1'b0);
        scl_low(1'b0);
        scl_high(1'b0);
        bus.scl_fall = 1'b1;
        tick();
        bus.stop_det = 1'b1;
        push(K_SDA, 1, 1'b1);
        push(K_ABORT, 1, 1'b1);
        tick();
        check("busy_after_stop", bus.tx_busy, 1'b0);
        idle(LOW + HOLD);
        send_byte(8'h80, 1'b0);

        // ack_req beats tx_load; a later tx_load while in ACK is ignored
        bus.tx_data = 8'hFF;
        bus.tx_load = 1'b1;
        bus.ack_req = 1'b1;
        push(K_SDA, 1 + HOLD, 1'b0);
        tick();
        idle(1);
        bus.tx_data = 8'hFF;
        bus.tx_load = 1'b1;
        tick();
        idle(LOW);
        slave_ack_clock(1'b0);

        // ack_req beats nack_req
        bus.ack_req  = 1'b1;
        bus.nack_req = 1'b1;
        push(K_SDA, 1 + HOLD, 1'b0);
        tick();
        idle(LOW);
        slave_ack_clock(1'b0);

        // START while the ACK drive is still pending: no low ever appears
        bus.ack_req = 1'b1;
        tick();
        bus.start_det = 1'b1;
        push(K_SDA, 1, 1'b1);
        push(K_ABORT, 1, 1'b1);
        tick();
        check("busy_after_start", bus.tx_busy, 1'b0);
        idle(LOW + HOLD);

        // Asynchronous reset mid-byte with a change pending
        bus.tx_data = 8'h00;
        bus.tx_load = 1'b1;
        push(K_SDA, 1 + HOLD, 1'b0);
        tick();
        idle(LOW);
        scl_high(1'b0);
        bus.scl_fall = 1'b1;
        tick();
        #2;
        chk_en = 1'b0;
        n_rst  = 1'b0;
        #1;
        check("arst_sda_out", bus.sda_out, 1'b1);
        check("arst_tx_busy", bus.tx_busy, 1'b0);
        check("arst_byte_done", bus.byte_done, 1'b0);
        check("arst_mack_valid", bus.mack_valid, 1'b0);
        check("arst_master_ack", bus.master_ack, 1'b0);
        check("arst_tx_abort", bus.tx_abort, 1'b0);
        sda_q.delete();
        done_q.delete();
        mval_q.delete();
        abort_q.delete();
        idle(3);
        n_rst    = 1'b1;
        prev_sda = 1'b1;
        chk_en   = 1'b1;
        idle(2);
        send_byte(8'h3C, 1'b0);
        check("ack_held_3c", bus.master_ack, 1'b1);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sda_tx_ctrl.md
# sda_tx_ctrl

Parametrised I2C slave SDA transmit controller, the successor to the fixed SDA output select. It owns the whole slave-side SDA drive: it serialises a DATA_W-bit byte MSB-first, generates ACK/NACK, and releases SDA to sample the master's acknowledge. Every SDA change lands a programmable number of clocks after SCL falls. It sits between the slave control FSM and the open-drain SDA pad, and consumes synchronised SCL edge pulses and START/STOP detect.

## Interface
- DATA_W, 8: bits per transmitted byte (≥2).
- HOLD_CYCLES, 2: clk cycles between the triggering event and the SDA change (0..15).
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- scl_rise  in  1  one-cycle pulse, synchronised SCL rising edge.
- scl_fall  in  1  one-cycle pulse, synchronised SCL falling edge.
- start_det  in  1  one-cycle pulse, START or repeated START seen.
- stop_det  in  1  one-cycle pulse, STOP seen.
- sda_in  in  1  synchronised SDA line value.
- tx_load  in  1  pulse; begin transmitting tx_data.
- tx_data  in  DATA_W  byte to transmit, sampled on tx_load.
- ack_req  in  1  pulse; drive ACK for the current SCL clock.
- nack_req  in  1  pulse; drive NACK (released) for the current SCL clock.
- sda_out  out  1  SDA drive value; 0 pulls low, 1 releases.
- tx_busy  out  1  high in every state except IDLE.
- byte_done  out  1  one-cycle pulse when a byte plus master-ACK slot completes.
- mack_valid  out  1  one-cycle pulse when the master ACK bit is sampled.
- master_ack  out  1  1 = master ACKed (sda_in low), held until the next mack_valid.
- tx_abort  out  1  one-cycle pulse when START/STOP kills a TX/MACK/ACK in progress.

## Operation
- Reset values: sda_out=1, tx_busy=0, byte_done=0, mack_valid=0, master_ack=0, tx_abort=0, state IDLE.
- States:
  - IDLE: sda_out=1.
  - TX: shift register drives bits.
  - MACK: SDA released; master acknowledge slot.
  - ACK: slave drives ACK or NACK.
- Pending changes: every sda_out change is scheduled and applies after the hold delay; see Timing.
- Transitions from IDLE:
  - ack_req → ACK with scheduled sda_out=0.
  - nack_req → ACK with scheduled sda_out=1.
  - tx_load → TX. Latch tx_data. Bit counter = DATA_W-1. Schedule sda_out = tx_data[DATA_W-1].
- TX: each scl_fall decrements the counter and schedules the next bit. The scl_fall with counter=0 instead schedules sda_out=1 and moves to MACK.
- MACK:
  - First scl_rise: master_ack = ~sda_in, mack_valid pulses.
  - Next scl_fall: byte_done pulses, → IDLE.
- ACK: next scl_fall schedules sda_out=1, → IDLE.
- Priority:
  - start_det/stop_det over everything: next cycle sda_out=1, state IDLE, pending schedule cancelled, counter cleared. tx_abort pulses if the state was TX, MACK or ACK.
  - Among simultaneous requests in IDLE: ack_req > nack_req > tx_load. The losers are dropped.
- Requests arriving outside IDLE are ignored. No state change, no output effect.
- A new scheduling event arriving while a change is pending replaces it and restarts the hold count.

## Timing
- Event at edge t (pulse sampled high): sda_out changes at edge t+1+HOLD_CYCLES. With HOLD_CYCLES=0 it changes at t+1.
- State and tx_busy update at t+1, independent of the hold delay.
- mack_valid and master_ack update at the edge after the scl_rise pulse.
- byte_done and tx_abort are registered and high for exactly one cycle at t+1.
- Reset mid-operation: asynchronous return to the reset values. No pulse is emitted.
- Integrator constraint: HOLD_CYCLES must be less than the SCL-low duration in clk cycles. The block does not check this.

## Structure
- Package i2c_pkg holds:
  - typedef enum logic [1:0] sda_tx_state_t {IDLE, TX, MACK, ACK}.
  - HOLD_W localparam = 4.
  - SDA_RELEASE = 1'b1.
- Sub-module sda_hold_timer owns the hold delay. It loads on a schedule event, counts HOLD_CYCLES down, accepts a cancel, and outputs an apply pulse plus the pending value.
- The top level holds the FSM, the DATA_W shift register, the $clog2(DATA_W) bit counter and the output registers.

## Test plan
All scenarios use DATA_W=8, HOLD_CYCLES=2.
- Byte with ACK: tx_load with 0xA5, then 8 scl_fall/scl_rise pairs → sda_out shows 1,0,1,0,0,1,0,1, each change 3 edges after its trigger. 9th clock with sda_in=0 at scl_rise → mack_valid, master_ack=1. Next scl_fall → byte_done, tx_busy=0.
- Master NACK: send 0xFF with sda_in=1 during the ACK slot → master_ack=0 and byte_done pulses. sda_out stays 1 throughout.
- Slave ACK: ack_req → sda_out=0 three edges later. scl_fall → sda_out=1 three edges later, state IDLE.
- Abort: stop_det after 3 bits of 0x00 → sda_out=1 next edge, tx_abort pulses once, no byte_done. A later tx_load with 0x80 transmits correctly.
- Collisions:
  - ack_req and tx_load in the same cycle → ACK taken and tx_load dropped; sda_out never shows the tx MSB.
  - tx_load while busy → ignored.
- Reset: n_rst low mid-byte, asynchronous to clk → sda_out=1 and all pulses 0 immediately.
